// File: rtl/ex_div_unit_pkg.sv
// Shared types and constants for the EX-stage divider.
package ex_div_unit_pkg;

    // Default operand/result width; the iteration count equals this width.
    localparam int DIV_WIDTH = 32;

    // Stall request levels seen by CTRL.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Divider FSM states (2-bit encoding shared with debug tooling).
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_ZERO = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_if.sv
// EX <-> divider bundle.
//
// Handshake: the EX stage (master) raises div_start with operands and
// div_signed and keeps all of them stable while stallreq_for_ex is high.
// The divider (slave) holds stallreq_for_ex high until the result is
// ready. It then drops the stall and pulses div_ready for exactly one
// cycle with div_lo/div_hi valid. div_cancel aborts the transaction in any
// cycle: the stall drops in the same cycle and no div_ready follows.
// div_lo/div_hi are only meaningful when div_ready is high.
interface ex_div_unit_if #(parameter int WIDTH = 32);
    logic             div_start;
    logic             div_signed;
    logic             div_cancel;
    logic [WIDTH-1:0] opdata1;
    logic [WIDTH-1:0] opdata2;
    logic             stallreq_for_ex;
    logic             div_ready;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] div_hi;

    modport master (
        output div_start, div_signed, div_cancel, opdata1, opdata2,
        input  stallreq_for_ex, div_ready, div_lo, div_hi
    );

    modport slave (
        input  div_start, div_signed, div_cancel, opdata1, opdata2,
        output stallreq_for_ex, div_ready, div_lo, div_hi
    );
endinterface

// File: rtl/ex_div_unit_sign_fix.sv
// Sign handling around an unsigned magnitude divider: absolute values on
// entry, conditional negation of quotient/remainder on exit. Purely
// combinational so a multiplier can reuse it.
module div_sign_fix
    import ex_div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] op1_abs,
    output logic [WIDTH-1:0] op2_abs,
    output logic             op1_neg,
    output logic             op2_neg,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] rem,
    input  logic             quo_neg,
    input  logic             rem_neg,
    output logic [WIDTH-1:0] quo_out,
    output logic [WIDTH-1:0] rem_out
);

    // Entry: a negative operand is only recognised in signed mode. MIN_INT
    // maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        op1_neg = is_signed & op1[WIDTH-1];
        op2_neg = is_signed & op2[WIDTH-1];
        op1_abs = op1_neg ? (~op1 + 1'b1) : op1;
        op2_abs = op2_neg ? (~op2 + 1'b1) : op2;
    end

    // Exit: restore signs on the unsigned quotient and remainder.
    always_comb begin
        quo_out = quo_neg ? (~quo + 1'b1) : quo;
        rem_out = rem_neg ? (~rem + 1'b1) : rem;
    end

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage. Requests a
// pipeline stall while a divide is in flight and releases it in the cycle
// the result is presented with div_ready.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    ex_div_unit_if.slave bus,
    output div_state_e   dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e         state;
    logic [CNT_W-1:0]   cnt;
    // {partial remainder, dividend/quotient} shift register
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   dvs;
    logic               neg1_q;
    logic               neg2_q;
    logic               ready_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic               stall;

    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic               op1_neg;
    logic               op2_neg;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    logic [WIDTH:0]     partial;
    logic [WIDTH-1:0]   trial;
    logic               fits;

    div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .is_signed (bus.div_signed),
        .op1       (bus.opdata1),
        .op2       (bus.opdata2),
        .op1_abs   (op1_abs),
        .op2_abs   (op2_abs),
        .op1_neg   (op1_neg),
        .op2_neg   (op2_neg),
        .quo       (acc_next[WIDTH-1:0]),
        .rem       (acc_next[2*WIDTH-1:WIDTH]),
        .quo_neg   (neg1_q ^ neg2_q),
        .rem_neg   (neg1_q),
        .quo_out   (quo_fix),
        .rem_out   (rem_fix)
    );

    // One restoring step: shift left, try subtracting the divisor from the
    // WIDTH+1-bit partial remainder, keep the difference if it fits. When it
    // fits the difference is below the divisor, so WIDTH bits hold it.
    always_comb begin
        partial  = acc[2*WIDTH-1:WIDTH-1];
        fits     = (partial >= {1'b0, dvs});
        trial    = partial[WIDTH-1:0] - dvs;
        acc_next = fits ? {trial, acc[WIDTH-2:0], 1'b1}
                        : {acc[2*WIDTH-2:0], 1'b0};
    end

    // Stall request: rises combinationally with a start in IDLE so a
    // back-to-back divide costs no extra bubble; cancel drops it at once.
    always_comb begin
        stall = NO_STOP;
        case (state)
            DIV_IDLE: if (bus.div_start && !bus.div_cancel) stall = STOP;
            DIV_BUSY,
            DIV_ZERO: if (!bus.div_cancel) stall = STOP;
            default:  stall = NO_STOP;
        endcase
    end

    // Divider FSM with counter, shift register and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            acc     <= '0;
            dvs     <= '0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            ready_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else if (bus.div_cancel) begin
            state   <= DIV_IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.div_start) begin
                        cnt <= '0;
                        if (bus.opdata2 == '0) begin
                            // Keep the raw dividend; it becomes the remainder.
                            acc   <= {{WIDTH{1'b0}}, bus.opdata1};
                            state <= DIV_ZERO;
                        end else begin
                            acc    <= {{WIDTH{1'b0}}, op1_abs};
                            dvs    <= op2_abs;
                            neg1_q <= op1_neg;
                            neg2_q <= op2_neg;
                            state  <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state   <= DIV_DONE;
                        ready_q <= 1'b1;
                        lo_q    <= quo_fix;
                        hi_q    <= rem_fix;
                    end
                end
                DIV_ZERO: begin
                    state   <= DIV_DONE;
                    ready_q <= 1'b1;
                    lo_q    <= '1;
                    hi_q    <= acc[WIDTH-1:0];
                end
                DIV_DONE: begin
                    state   <= DIV_IDLE;
                    ready_q <= 1'b0;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign bus.stallreq_for_ex = stall;
    assign bus.div_ready       = ready_q;
    assign bus.div_lo          = lo_q;
    assign bus.div_hi          = hi_q;
    assign dbg_state           = state;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed and randomized bench for ex_div_unit, checked against a plain
// arithmetic divide model.
module tb_ex_div_unit;
    import ex_div_unit_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

    logic       clk = 1'b0;
    logic       rst;
    div_state_e dbg_state;
    int         vectors = 0;
    int         miscompares = 0;

    ex_div_unit_if #(.WIDTH(W)) bus();

    ex_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division, remainder takes the dividend's sign,
    // divide-by-zero gives all-ones / dividend. 64-bit math avoids overflow.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sgn,
                                    output logic [W-1:0] lo, output logic [W-1:0] hi);
        longint sa, sb, q, r;
        if (b == '0) begin
            lo = '1;
            hi = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = W'(q);
            hi = W'(r);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Issue one divide, scramble operands while stalled, check latency and
    // result. Leaves div_start high so a following call runs back-to-back.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           input string tag,
                           output logic [W-1:0] got_lo, output logic [W-1:0] got_hi);
        logic [W-1:0] elo, ehi;
        int ncyc, nstall, exp_cyc;
        bit seen;
        ncyc = 0; nstall = 0; seen = 0;
        exp_cyc = (b == '0) ? 2 : W + 1;
        ref_div(a, b, sgn, elo, ehi);
        @(posedge clk); #1;
        bus.div_start  = 1'b1;
        bus.div_signed = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.div_cancel = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.div_ready) begin
                seen = 1;
                break;
            end
            ncyc++;
            if (bus.stallreq_for_ex) nstall++;
            @(posedge clk); #1;
            bus.opdata1 = $urandom;
            bus.opdata2 = $urandom;
        end
        got_lo = bus.div_lo;
        got_hi = bus.div_hi;
        check({tag, " ready_seen"}, W'(seen), 1);
        if (seen) begin
            check({tag, " stall_cycles"}, W'(nstall), W'(exp_cyc));
            check({tag, " wait_cycles"}, W'(ncyc), W'(exp_cyc));
            check({tag, " stall_in_ready"}, W'(bus.stallreq_for_ex), 0);
            check({tag, " lo"}, bus.div_lo, elo);
            check({tag, " hi"}, bus.div_hi, ehi);
        end
    endtask

    // Idle cycles with no request: no stall, no ready pulse.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.div_start = 1'b0;
            @(negedge clk);
            check("idle ready", W'(bus.div_ready), 0);
            check("idle stall", W'(bus.stallreq_for_ex), 0);
        end
    endtask

    initial begin
        logic [W-1:0] lo, hi, a, b;
        logic sgn;
        int pulses;

        // Reset
        rst = 1'b1;
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_cancel = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst lo", bus.div_lo, 0);
        check("rst hi", bus.div_hi, 0);
        check("rst ready", W'(bus.div_ready), 0);
        check("rst stall", W'(bus.stallreq_for_ex), 0);
        check("rst state", W'(dbg_state), W'(DIV_IDLE));
        bus.div_start = 1'b1;
        #1;
        check("rst stall follows start", W'(bus.stallreq_for_ex), 1);
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        rst = 1'b0;
        idle(1);

        // DIVU 100/7
        run_div(100, 7, 1'b0, "divu_100_7", lo, hi);
        check("divu_100_7 lo const", lo, 14);
        check("divu_100_7 hi const", hi, 2);
        idle(2);

        // Signed sign fix-up
        run_div(-32'sd7, 2, 1'b1, "div_m7_2", lo, hi);
        check("div_m7_2 lo const", lo, 32'hFFFF_FFFD);
        check("div_m7_2 hi const", hi, 32'hFFFF_FFFF);
        idle(1);
        run_div(7, -32'sd2, 1'b1, "div_7_m2", lo, hi);
        check("div_7_m2 lo const", lo, 32'hFFFF_FFFD);
        check("div_7_m2 hi const", hi, 1);
        idle(1);

        // Divide by zero
        run_div(5, 0, 1'b1, "div_5_0", lo, hi);
        check("div_5_0 lo const", lo, 32'hFFFF_FFFF);
        check("div_5_0 hi const", hi, 5);
        idle(1);

        // Overflow corner, signed then unsigned
        run_div(MIN_INT, 32'hFFFF_FFFF, 1'b1, "div_min_m1", lo, hi);
        check("div_min_m1 lo const", lo, MIN_INT);
        check("div_min_m1 hi const", hi, 0);
        idle(1);
        run_div(MIN_INT, 32'hFFFF_FFFF, 1'b0, "divu_min_m1", lo, hi);
        check("divu_min_m1 lo const", lo, 0);
        check("divu_min_m1 hi const", hi, MIN_INT);
        idle(1);

        // Cancel in BUSY cycle 10
        @(posedge clk); #1;
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.opdata1    = 1000;
        bus.opdata2    = 3;
        repeat (10) @(posedge clk);
        #1;
        bus.div_cancel = 1'b1;
        @(negedge clk);
        check("cancel state before", W'(dbg_state), W'(DIV_BUSY));
        check("cancel stall", W'(bus.stallreq_for_ex), 0);
        check("cancel ready", W'(bus.div_ready), 0);
        @(posedge clk); #1;
        bus.div_cancel = 1'b0;
        bus.div_start  = 1'b0;
        @(negedge clk);
        check("cancel idle state", W'(dbg_state), W'(DIV_IDLE));
        check("cancel idle stall", W'(bus.stallreq_for_ex), 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.div_ready) pulses++;
        end
        check("cancel no ready pulse", W'(pulses), 0);
        run_div(1000, 3, 1'b0, "after_cancel", lo, hi);
        idle(1);

        // Back-to-back DIVUs
        run_div(9, 2, 1'b0, "b2b_9_2", lo, hi);
        check("b2b_9_2 lo const", lo, 4);
        check("b2b_9_2 hi const", hi, 1);
        run_div(9, 3, 1'b0, "b2b_9_3", lo, hi);
        check("b2b_9_3 lo const", lo, 3);
        check("b2b_9_3 hi const", hi, 0);
        idle(1);

        // Randomized divides, mixing idle gaps and back-to-back issue
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = -W'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = MIN_INT;
            sgn = 1'($urandom_range(0, 1));
            run_div(a, b, sgn, $sformatf("rand%0d", i), lo, hi);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);

        // Reset in the middle of BUSY clears the outputs
        run_div(77, 5, 1'b0, "pre_rst", lo, hi);
        @(posedge clk); #1;
        bus.div_start = 1'b1;
        bus.opdata1   = 1234;
        bus.opdata2   = 7;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.div_start = 1'b0;
        @(posedge clk); #1;
        check("midrst lo", bus.div_lo, 0);
        check("midrst hi", bus.div_hi, 0);
        check("midrst ready", W'(bus.div_ready), 0);
        check("midrst stall", W'(bus.stallreq_for_ex), 0);
        check("midrst state", W'(dbg_state), W'(DIV_IDLE));
        rst = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
